// File: rtl/kernel_cnn_mul_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : kernel_cnn_mul_arbiter_if
// Purpose  : Bundle of the requester operand ports, the shared-multiplier
//            operand/product wires and the tagged response port used by
//            kernel_cnn_mul_arbiter.
// Signals  : req_valid/req_ready   per-requester handshake (NUM_REQ bits)
//            req_din0/req_din1     packed operands, requester i at [i*W +: W]
//            mul_din0/mul_din1     operands to the shared multiplier
//            mul_dout              combinational product from the multiplier
//            rsp_valid/rsp_ready   response handshake
//            rsp_dout/rsp_id       product (low DOUT_W bits) and owner tag
// Modports : master - requesters, multiplier and response sink (environment)
//            slave  - the arbiter
// Revision : 1.0 - initial release
// ============================================================================
interface kernel_cnn_mul_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DIN0_W  = 6,
   parameter int DIN1_W  = 7,
   parameter int DOUT_W  = 12,
   parameter int ID_W    = 2
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*DIN0_W-1:0] req_din0;
   logic [NUM_REQ*DIN1_W-1:0] req_din1;
   logic [DIN0_W-1:0]         mul_din0;
   logic [DIN1_W-1:0]         mul_din1;
   logic [DOUT_W-1:0]         mul_dout;
   logic                      rsp_valid;
   logic                      rsp_ready;
   logic [DOUT_W-1:0]         rsp_dout;
   logic [ID_W-1:0]           rsp_id;

   modport master (
      output req_valid, req_din0, req_din1, mul_dout, rsp_ready,
      input  req_ready, mul_din0, mul_din1, rsp_valid, rsp_dout, rsp_id
   );

   modport slave (
      input  req_valid, req_din0, req_din1, mul_dout, rsp_ready,
      output req_ready, mul_din0, mul_din1, rsp_valid, rsp_dout, rsp_id
   );
endinterface
`default_nettype wire

// File: rtl/kernel_cnn_mul_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : kernel_cnn_mul_arbiter
// Purpose  : Round-robin arbiter that time-shares one external combinational
//            unsigned multiplier among NUM_REQ requesters. The granted
//            requester's operands drive the multiplier; on acceptance the
//            product (low DOUT_W bits) is captured into a one-entry output
//            register tagged with the requester index.
// Ports    : ap_clk    in   clock, rising edge
//            ap_rst_n  in   asynchronous reset, active low
//            bus       slave modport of kernel_cnn_mul_arbiter_if
//                      (req_*, mul_*, rsp_* signals)
// Revision : 1.0 - initial release
// ============================================================================
module kernel_cnn_mul_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DIN0_W  = 6,
   parameter int DIN1_W  = 7,
   parameter int DOUT_W  = 12,
   parameter int ID_W    = 2
) (
   input  logic                    ap_clk,
   input  logic                    ap_rst_n,
   kernel_cnn_mul_arbiter_if.slave bus
);

   // One extra bit so ptr + offset never overflows before the explicit wrap.
   localparam logic [ID_W:0]   c_num_req = (ID_W+1)'(NUM_REQ);
   localparam logic [ID_W-1:0] c_last_id = ID_W'(NUM_REQ - 1);

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t              r_state;
   logic [DOUT_W-1:0]   r_rsp_dout;
   logic [ID_W-1:0]     r_rsp_id;
   logic [ID_W-1:0]     r_rr_ptr;

   logic [NUM_REQ-1:0]  w_grant;
   logic [ID_W-1:0]     w_gnt_id;
   logic                w_gnt_any;
   logic [ID_W:0]       w_sum;
   logic                w_can_accept;
   logic                w_xfer;
   logic [DIN0_W-1:0]   w_mul_din0;
   logic [DIN1_W-1:0]   w_mul_din1;

   // Rotating priority search: offset k from the pointer, wrapped modulo
   // NUM_REQ so non-power-of-two requester counts never index past the end.
   always_comb begin
      w_grant   = '0;
      w_gnt_id  = '0;
      w_gnt_any = 1'b0;
      w_sum     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
         if (w_sum >= c_num_req) begin
            w_sum = w_sum - c_num_req;
         end
         if (!w_gnt_any && bus.req_valid[w_sum[ID_W-1:0]]) begin
            w_grant[w_sum[ID_W-1:0]] = 1'b1;
            w_gnt_id                 = w_sum[ID_W-1:0];
            w_gnt_any                = 1'b1;
         end
      end
   end

   // Operand mux; the one-hot grant makes an AND-OR mux sufficient and
   // yields zero operands when nobody is granted.
   always_comb begin
      w_mul_din0 = '0;
      w_mul_din1 = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_grant[i]) begin
            w_mul_din0 = w_mul_din0 | bus.req_din0[i*DIN0_W +: DIN0_W];
            w_mul_din1 = w_mul_din1 | bus.req_din1[i*DIN1_W +: DIN1_W];
         end
      end
   end

   // The output slot frees up in the same cycle it drains, giving
   // back-to-back throughput.
   assign w_can_accept = (r_state == ST_EMPTY) | bus.rsp_ready;
   assign w_xfer       = w_gnt_any & w_can_accept;

   // Gated with reset so no requester sees an accept while reset is held.
   assign bus.req_ready = w_grant & {NUM_REQ{w_can_accept & ap_rst_n}};
   assign bus.mul_din0  = w_mul_din0;
   assign bus.mul_din1  = w_mul_din1;
   assign bus.rsp_valid = (r_state == ST_FULL);
   assign bus.rsp_dout  = r_rsp_dout;
   assign bus.rsp_id    = r_rsp_id;

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_state    <= ST_EMPTY;
         r_rsp_dout <= '0;
         r_rsp_id   <= '0;
         r_rr_ptr   <= '0;
      end else begin
         if (w_xfer) begin
            r_rsp_dout <= bus.mul_dout;
            r_rsp_id   <= w_gnt_id;
            r_rr_ptr   <= (w_gnt_id == c_last_id) ? '0 : w_gnt_id + ID_W'(1);
         end
         case (r_state)
            ST_EMPTY: begin
               if (w_xfer) begin
                  r_state <= ST_FULL;
               end
            end
            ST_FULL: begin
               // A simultaneous drain and accept keeps the slot full.
               if (!w_xfer && bus.rsp_ready) begin
                  r_state <= ST_EMPTY;
               end
            end
            default: r_state <= ST_EMPTY;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_kernel_cnn_mul_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_kernel_cnn_mul_arbiter
// Purpose  : Directed self-checking bench for kernel_cnn_mul_arbiter with a
//            behavioural round-robin/response model compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kernel_cnn_mul_arbiter;

   localparam int NUM_REQ = 4;
   localparam int DIN0_W  = 6;
   localparam int DIN1_W  = 7;
   localparam int DOUT_W  = 12;
   localparam int ID_W    = 2;

   logic ap_clk   = 1'b0;
   logic ap_rst_n = 1'b1;

   kernel_cnn_mul_arbiter_if #(
      .NUM_REQ(NUM_REQ), .DIN0_W(DIN0_W), .DIN1_W(DIN1_W),
      .DOUT_W(DOUT_W), .ID_W(ID_W)
   ) bus ();

   kernel_cnn_mul_arbiter #(
      .NUM_REQ(NUM_REQ), .DIN0_W(DIN0_W), .DIN1_W(DIN1_W),
      .DOUT_W(DOUT_W), .ID_W(ID_W)
   ) dut (
      .ap_clk  (ap_clk),
      .ap_rst_n(ap_rst_n),
      .bus     (bus)
   );

   // Shared combinational multiplier
   logic [12:0] w_full;
   assign w_full       = {7'd0, bus.mul_din0} * {6'd0, bus.mul_din1};
   assign bus.mul_dout = w_full[11:0];

   always #5 ap_clk = ~ap_clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          m_ptr   = 0;
   logic        m_valid = 1'b0;
   int          m_dout  = 0;
   int          m_id    = 0;
   int          n_ptr   = 0;
   logic        n_valid = 1'b0;
   int          n_dout  = 0;
   int          n_id    = 0;

   logic [NUM_REQ-1:0]        acc_last  = '0;
   logic [NUM_REQ-1:0]        prev_pend = '0;
   logic [NUM_REQ*DIN0_W-1:0] prev_d0   = '0;
   logic [NUM_REQ*DIN1_W-1:0] prev_d1   = '0;

   int acc_q[$];
   int rid_q[$];
   int rdout_q[$];

   always @(negedge ap_clk) begin : p_compare
      int g;
      int idx;
      logic can;
      logic [NUM_REQ-1:0] e_ready;
      int ea;
      int eb;
      g = -1;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (m_ptr + k) % NUM_REQ;
         if (g < 0 && bus.req_valid[idx]) g = idx;
      end
      can     = !m_valid || bus.rsp_ready;
      e_ready = '0;
      ea      = 0;
      eb      = 0;
      if (g >= 0) begin
         ea = int'(bus.req_din0[g*DIN0_W +: DIN0_W]);
         eb = int'(bus.req_din1[g*DIN1_W +: DIN1_W]);
         if (ap_rst_n && can) e_ready[g] = 1'b1;
      end

      chk("req_ready", 32'(bus.req_ready), 32'(e_ready));
      chk("mul_din0",  32'(bus.mul_din0),  ea);
      chk("mul_din1",  32'(bus.mul_din1),  eb);
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_valid));
      chk("rsp_dout",  32'(bus.rsp_dout),  m_dout);
      chk("rsp_id",    32'(bus.rsp_id),    m_id);

      // requester rule: pending requests stay valid with stable operands
      if (ap_rst_n) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (prev_pend[i]) begin
               chk($sformatf("req_hold_valid%0d", i), 32'(bus.req_valid[i]), 1);
               chk($sformatf("req_hold_din%0d", i),
                   {bus.req_din0[i*DIN0_W +: DIN0_W], bus.req_din1[i*DIN1_W +: DIN1_W]},
                   {prev_d0[i*DIN0_W +: DIN0_W], prev_d1[i*DIN1_W +: DIN1_W]});
            end
         end
      end

      acc_last  = bus.req_valid & bus.req_ready;
      prev_pend = bus.req_valid & ~acc_last;
      prev_d0   = bus.req_din0;
      prev_d1   = bus.req_din1;
      for (int i = 0; i < NUM_REQ; i++) if (acc_last[i]) acc_q.push_back(i);
      if (bus.rsp_valid && bus.rsp_ready) begin
         rid_q.push_back(int'(bus.rsp_id));
         rdout_q.push_back(int'(bus.rsp_dout));
      end

      n_valid = m_valid;
      n_dout  = m_dout;
      n_id    = m_id;
      n_ptr   = m_ptr;
      if (ap_rst_n && g >= 0 && can) begin
         n_valid = 1'b1;
         n_dout  = (ea * eb) % 4096;
         n_id    = g;
         n_ptr   = (g + 1) % NUM_REQ;
      end else if (m_valid && bus.rsp_ready) begin
         n_valid = 1'b0;
      end
   end

   always @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         m_valid <= 1'b0;
         m_dout  <= 0;
         m_id    <= 0;
         m_ptr   <= 0;
      end else begin
         m_valid <= n_valid;
         m_dout  <= n_dout;
         m_id    <= n_id;
         m_ptr   <= n_ptr;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge ap_clk);
      #1;
      bus.req_valid = bus.req_valid & ~acc_last;
   endtask

   task automatic post(input int i, input int a, input int b);
      bus.req_din0[i*DIN0_W +: DIN0_W] = DIN0_W'(a);
      bus.req_din1[i*DIN1_W +: DIN1_W] = DIN1_W'(b);
      bus.req_valid[i]                 = 1'b1;
   endtask

   task automatic do_reset();
      ap_rst_n = 1'b0;
      #1;
      tick();
      tick();
      ap_rst_n = 1'b1;
   endtask

   task automatic clear_logs();
      acc_q.delete();
      rid_q.delete();
      rdout_q.delete();
   endtask

   int it_a [8] = '{5, 10, 63, 40, 50, 33, 1, 0};
   int it_b [8] = '{7, 11, 127, 100, 90, 125, 1, 127};
   int ex_d [8] = '{35, 110, 3905, 4000, 404, 29, 1, 0};
   int ex_id[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
   int t5_d [4] = '{63, 64, 81, 4095};
   int t4_id[3] = '{2, 3, 1};

   initial begin : p_main
      int p;
      int n;
      bus.req_valid = '0;
      bus.req_din0  = '0;
      bus.req_din1  = '0;
      bus.rsp_ready = 1'b1;

      // Reset state
      #2;
      ap_rst_n = 1'b0;
      #1;
      tick();
      chk("reset_req_ready", 32'(bus.req_ready), 0);
      tick();
      ap_rst_n = 1'b1;
      chk("reset_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("reset_rsp_dout",  32'(bus.rsp_dout),  0);
      chk("reset_rsp_id",    32'(bus.rsp_id),    0);

      // T1: single request, truncated product
      post(0, 63, 127);
      #1;
      chk("t1_req_ready", 32'(bus.req_ready), 32'b0001);
      chk("t1_mul_din0",  32'(bus.mul_din0),  63);
      tick();
      chk("t1_rsp_valid", 32'(bus.rsp_valid), 1);
      chk("t1_rsp_dout",  32'(bus.rsp_dout),  3905);
      chk("t1_rsp_id",    32'(bus.rsp_id),    0);
      tick();
      chk("t1_drained",   32'(bus.rsp_valid), 0);
      chk("t1_mul_zero0", 32'(bus.mul_din0),  0);
      chk("t1_mul_zero1", 32'(bus.mul_din1),  0);

      // T2: all valid, back-to-back round robin
      do_reset();
      clear_logs();
      for (int i = 0; i < NUM_REQ; i++) post(i, it_a[i], it_b[i]);
      p = 4;
      for (int t = 0; t < 8; t++) begin
         tick();
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!bus.req_valid[i] && p < 8) begin
               post(i, it_a[p], it_b[p]);
               p++;
            end
         end
      end
      chk("t2_accept_count", acc_q.size(), 8);
      tick();
      chk("t2_rsp_count", rid_q.size(), 8);
      for (int k = 0; k < 8; k++) begin
         if (k < acc_q.size()) chk($sformatf("t2_acc%0d", k), acc_q[k], ex_id[k]);
         if (k < rid_q.size()) begin
            chk($sformatf("t2_rsp_id%0d", k),   rid_q[k],   ex_id[k]);
            chk($sformatf("t2_rsp_dout%0d", k), rdout_q[k], ex_d[k]);
         end
      end

      // T3: backpressure, then accept with no bubble
      bus.rsp_ready = 1'b0;
      post(0, 3, 4);
      tick();
      post(1, 5, 5);
      repeat (5) tick();
      chk("t3_ready_blocked", 32'(bus.req_ready), 0);
      chk("t3_rsp_valid",     32'(bus.rsp_valid), 1);
      chk("t3_rsp_dout",      32'(bus.rsp_dout),  12);
      chk("t3_rsp_id",        32'(bus.rsp_id),    0);
      bus.rsp_ready = 1'b1;
      #1;
      chk("t3_ready_release", 32'(bus.req_ready), 32'b0010);
      tick();
      chk("t3_rsp_dout2", 32'(bus.rsp_dout),  25);
      chk("t3_rsp_id2",   32'(bus.rsp_id),    1);
      chk("t3_no_bubble", 32'(bus.rsp_valid), 1);

      // T4: pointer after requester 2 prefers 3 over 1
      clear_logs();
      post(2, 2, 3);
      tick();
      post(1, 4, 4);
      post(3, 6, 6);
      #1;
      chk("t4_grant3", 32'(bus.req_ready), 32'b1000);
      tick();
      chk("t4_grant1", 32'(bus.req_ready), 32'b0010);
      tick();
      tick();
      chk("t4_acc_count", acc_q.size(), 3);
      for (int k = 0; k < 3; k++)
         if (k < acc_q.size()) chk($sformatf("t4_acc%0d", k), acc_q[k], t4_id[k]);

      // T5: asynchronous reset mid-stream
      post(0, 7, 9);
      post(1, 8, 8);
      post(2, 9, 9);
      post(3, 63, 65);
      tick();
      post(2, 9, 9);
      chk("t5_inflight", 32'(bus.rsp_valid), 1);
      ap_rst_n = 1'b0;
      #1;
      chk("t5_async_valid", 32'(bus.rsp_valid), 0);
      chk("t5_async_ready", 32'(bus.req_ready), 0);
      tick();
      tick();
      ap_rst_n = 1'b1;
      clear_logs();
      #1;
      chk("t5_first_grant", 32'(bus.req_ready), 32'b0001);

      // T6: drain to idle
      n = 0;
      while ((bus.req_valid != '0 || bus.rsp_valid) && n < 40) begin
         tick();
         n++;
      end
      chk("t6_drain_done", 32'(n < 40), 1);
      chk("t6_rsp_valid",  32'(bus.rsp_valid), 0);
      chk("t6_mul_din0",   32'(bus.mul_din0),  0);
      chk("t6_mul_din1",   32'(bus.mul_din1),  0);
      chk("t5_rsp_count",  rid_q.size(), 4);
      for (int k = 0; k < 4; k++) begin
         if (k < rid_q.size()) begin
            chk($sformatf("t5_rsp_id%0d", k),   rid_q[k],   k);
            chk($sformatf("t5_rsp_dout%0d", k), rdout_q[k], t5_d[k]);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin : p_watchdog
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
